// File: rtl/counter_mod.sv
// ---------------------------------------------------------------------------
// counter_mod -- parameterised up/down counter with load, terminal-count
// pulse and optional one-shot stop.
//
// Optional feature macro: COUNTER_PRESCALE_EN
//   Defined   : an internal divider counts enabled cycles 0..PRESCALE-1 and
//               only the cycle where it reaches PRESCALE-1 becomes a count
//               step.
//   Undefined : every enabled cycle is a count step; PRESCALE has no effect
//               on behaviour.
//
// Parameters
//   WIDTH    counter width in bits (1..32)
//   MAX      terminal (largest) count value, 1..2**WIDTH-1
//   ONESHOT  0 = wrap at terminal count, 1 = stop and raise done
//   PRESCALE enabled cycles per count step (2..256), prescaled build only
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   en        in   count enable
//   up        in   1 = increment, 0 = decrement (sampled every cycle)
//   load      in   synchronous load strobe, overrides a step
//   load_val  in   value loaded on load, clamped to MAX
//   q         out  registered count value
//   wrap      out  registered one-cycle pulse after a terminal event
//   done      out  registered one-shot completion flag (0 when ONESHOT=0)
// ---------------------------------------------------------------------------
module counter_mod #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX      = 16'hFFFF,
  parameter int unsigned ONESHOT  = 0,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_V = '0;

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_mod: WIDTH must be 1..32");
  end
  if (MAX < 1 || ((64'(MAX) >> WIDTH) != 64'd0)) begin : g_bad_max
    $error("counter_mod: MAX must be 1..2**WIDTH-1");
  end
  if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
    $error("counter_mod: PRESCALE must be 2..256");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  // tick qualifies an enabled cycle as a count step.
  logic tick;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned      DIV_W    = $clog2(PRESCALE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);

  logic [DIV_W-1:0] div_q, div_d;

  // The divider only advances on cycles that could step (en=1, not done),
  // so en=0 and a finished one-shot both freeze it. Load restarts it.
  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (load) begin
      div_d = '0;
    end else if (en && !done_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        tick  = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  logic step;
  logic terminal;

  assign step     = en & ~done_q & tick;
  assign terminal = step & (up ? (cnt_q == MAX_V) : (cnt_q == ZERO_V));

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    done_d = done_q;
    if (load) begin
      // Clamp keeps q inside 0..MAX; load never produces a wrap pulse.
      cnt_d  = (load_val > MAX_V) ? MAX_V : load_val;
      done_d = 1'b0;
    end else if (step) begin
      wrap_d = terminal;
      if (terminal) begin
        if (ONESHOT != 0) begin
          done_d = 1'b1;                    // q holds at the terminal value
        end else begin
          cnt_d = up ? ZERO_V : MAX_V;
        end
      end else begin
        cnt_d = up ? (cnt_q + ONE_V) : (cnt_q - ONE_V);
      end
    end
    if (ONESHOT == 0) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;
  assign done = done_q;

endmodule

// File: tb/tb_counter_mod.sv
// ---------------------------------------------------------------------------
// tb_counter_mod -- self-checking bench for counter_mod.
// Three instances share the control inputs:
//   u_wrap : WIDTH=16 MAX=9  ONESHOT=0 PRESCALE=4
//   u_one  : WIDTH=16 MAX=3  ONESHOT=1 PRESCALE=4
//   u_full : WIDTH=4  MAX=15 ONESHOT=0 PRESCALE=2
// ---------------------------------------------------------------------------
module tb_counter_mod;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [15:0] lv;
  logic [3:0]  lv4;
  logic [15:0] q_w, q_o;
  logic [3:0]  q_f;
  logic        w_w, w_o, w_f;
  logic        d_w, d_o, d_f;

  always #5 clk = ~clk;

  counter_mod #(.WIDTH(16), .MAX(9), .ONESHOT(0), .PRESCALE(4)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv), .q(q_w), .wrap(w_w), .done(d_w));

  counter_mod #(.WIDTH(16), .MAX(3), .ONESHOT(1), .PRESCALE(4)) u_one (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv), .q(q_o), .wrap(w_o), .done(d_o));

  counter_mod #(.WIDTH(4), .MAX(15), .ONESHOT(0), .PRESCALE(2)) u_full (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv4), .q(q_f), .wrap(w_f), .done(d_f));

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
`ifdef COUNTER_PRESCALE_EN
  localparam bit PS = 1'b1;
`else
  localparam bit PS = 1'b0;
`endif

  int mmax[3] = '{9, 3, 15};
  int mone[3] = '{0, 1, 0};
  int mpre[3] = '{4, 4, 2};
  int mq[3], mw[3], md[3], mdiv[3];

  // Counting modulo MAX+1 with arithmetic, one-shot stops at the terminal.
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int lvk;
      int nxt;
      bit tk;
      bit term;
      lvk = (k == 2) ? int'(lv4) : int'(lv);
      if (reset) begin
        mq[k] = 0; mw[k] = 0; md[k] = 0; mdiv[k] = 0;
      end else if (load) begin
        mq[k] = (lvk > mmax[k]) ? mmax[k] : lvk;
        mw[k] = 0; md[k] = 0; mdiv[k] = 0;
      end else begin
        mw[k] = 0;
        if (en && md[k] == 0) begin
          tk = 1'b1;
          if (PS) begin
            if (mdiv[k] == mpre[k] - 1) mdiv[k] = 0;
            else begin mdiv[k]++; tk = 1'b0; end
          end
          if (tk) begin
            nxt  = up ? (mq[k] + 1) % (mmax[k] + 1) : (mq[k] + mmax[k]) % (mmax[k] + 1);
            term = up ? (mq[k] == mmax[k]) : (mq[k] == 0);
            mw[k] = term;
            if (term && mone[k] != 0) md[k] = 1;
            else mq[k] = nxt;
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    chk("wrap_q", int'(q_w), mq[0]);
    chk("wrap_wrap", int'(w_w), mw[0]);
    chk("wrap_done", int'(d_w), md[0]);
    chk("one_q", int'(q_o), mq[1]);
    chk("one_wrap", int'(w_o), mw[1]);
    chk("one_done", int'(d_o), md[1]);
    chk("full_q", int'(q_f), mq[2]);
    chk("full_wrap", int'(w_f), mw[2]);
    chk("full_done", int'(d_f), md[2]);
  endtask

  // One clock: inputs are already set; sample #1 after the edge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic drive(input logic r, input logic e, input logic u,
                       input logic l, input logic [15:0] v);
    reset = r; en = e; up = u; load = l; lv = v; lv4 = v[3:0];
  endtask

  // ---------------- vector table (u_wrap, MAX=9) ----------------
  typedef struct {
    logic        rst, en, up, ld;
    logic [15:0] lv;
    int          eq;
    int          ew;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [15:0] v, input int eq, input int ew);
    vec_t t;
    t.rst = r; t.en = e; t.up = u; t.ld = l; t.lv = v; t.eq = eq; t.ew = ew;
    tbl.push_back(t);
  endtask

  int os_q[6] = '{1, 2, 3, 3, 3, 3};
  int os_d[6] = '{0, 0, 0, 1, 1, 1};
  int os_w[6] = '{0, 0, 0, 1, 0, 0};

  // ---------------- main sequence ----------------
  initial begin
    drive(1, 0, 1, 0, 0);

`ifndef COUNTER_PRESCALE_EN
    // reset 3 cycles, then idle
    for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 16'd0, 0, 0);
    add(0, 0, 1, 0, 16'd0, 0, 0);
    add(0, 0, 1, 0, 16'd0, 0, 0);
    // count up 12 cycles through the wrap
    for (int i = 1; i <= 12; i++) add(0, 1, 1, 0, 16'd0, i % 10, (i == 10) ? 1 : 0);
    // load 0, then count down through the wrap
    add(0, 1, 1, 1, 16'd0, 0, 0);
    add(0, 1, 0, 0, 16'd0, 9, 1);
    add(0, 1, 0, 0, 16'd0, 8, 0);
    // load beats step; clamp above MAX
    add(0, 1, 1, 1, 16'd5, 5, 0);
    add(0, 1, 1, 1, 16'd20, 9, 0);
    add(0, 1, 1, 0, 16'd0, 0, 1);
    // load at MAX while a terminal step would happen: no wrap
    add(0, 1, 1, 1, 16'd9, 9, 0);
    add(0, 1, 1, 1, 16'd9, 9, 0);
    add(0, 0, 1, 0, 16'd0, 9, 0);
    // reset beats load and en
    add(1, 1, 1, 1, 16'd5, 0, 0);
    add(0, 1, 0, 0, 16'd0, 9, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].ld, tbl[i].lv);
      cycle();
      chk("tbl_q", int'(q_w), tbl[i].eq);
      chk("tbl_wrap", int'(w_w), tbl[i].ew);
    end

    // one-shot run on u_one (MAX=3)
    drive(1, 0, 1, 0, 0);
    cycle();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 0, 0);
      cycle();
      chk("os_q", int'(q_o), os_q[i]);
      chk("os_done", int'(d_o), os_d[i]);
      chk("os_wrap", int'(w_o), os_w[i]);
    end
    drive(0, 1, 1, 1, 0);
    cycle();
    chk("os_reload_q", int'(q_o), 0);
    chk("os_reload_done", int'(d_o), 0);
    drive(0, 1, 1, 0, 0);
    cycle();
    chk("os_resume_q", int'(q_o), 1);
    // down terminal from 0 in one-shot
    drive(0, 1, 1, 1, 0);
    cycle();
    drive(0, 1, 0, 0, 0);
    cycle();
    chk("os_down_q", int'(q_o), 0);
    chk("os_down_done", int'(d_o), 1);
`else
    // prescaled counting on u_wrap (PRESCALE=4)
    for (int i = 0; i < 3; i++) cycle();
    chk("ps_reset_q", int'(q_w), 0);
    drive(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("ps_pre_q", int'(q_w), 0);
    cycle();
    chk("ps_first_q", int'(q_w), 1);
    cycle(); cycle();
    drive(0, 0, 1, 0, 0);
    cycle(); cycle();
    chk("ps_hold_q", int'(q_w), 1);
    drive(0, 1, 1, 0, 0);
    cycle();
    chk("ps_stretch_q", int'(q_w), 1);
    cycle();
    chk("ps_second_q", int'(q_w), 2);
    cycle(); cycle();
    drive(1, 1, 1, 0, 0);
    cycle();
    chk("ps_midreset_q", int'(q_w), 0);
    drive(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("ps_after_reset_q", int'(q_w), 0);
    cycle();
    chk("ps_after_reset_step", int'(q_w), 1);
`endif

    // randomized traffic checked against the model every cycle
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
            16'($urandom_range(0, 31)));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_mod.md
COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 Parameter WIDTH, default 16, counter width in bits (1..32).
REQ-002 Parameter MAX, default 16'hFFFF, terminal (largest) count value; range 1 to 2**WIDTH-1.
REQ-003 Parameter ONESHOT, default 0; 1 = stop at terminal count instead of wrapping.
REQ-004 Parameter PRESCALE, default 4, enable cycles per count step; range 2..256; used only when COUNTER_PRESCALE_EN is defined.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 en  input  1  count enable.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement; sampled every cycle.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  WIDTH  value loaded on load.
REQ-011 q  output  WIDTH  registered count value.
REQ-012 wrap  output  1  registered one-cycle pulse following a terminal event.
REQ-013 done  output  1  registered one-shot completion flag; constant 0 when ONESHOT=0.

Function
REQ-014 Update priority: reset, then load, then step, then hold.
REQ-015 "Step" is a cycle with en=1 and done=0 (prescaler gating per REQ-027/028).
REQ-016 Up step: q==MAX -> 0 (ONESHOT=0); otherwise q+1.
REQ-017 Down step: q==0 -> MAX (ONESHOT=0); otherwise q-1.
REQ-018 Terminal event: a step with up=1 and q==MAX, or a step with up=0 and q==0.
REQ-019 wrap = 1 for exactly the one cycle after a terminal event; otherwise 0; never asserted on load.
REQ-020 ONESHOT=1: on a terminal event, q holds its value, done sets next cycle, and wrap pulses per REQ-019.
REQ-021 ONESHOT=1: while done=1, en is ignored and q holds; load clears done and loads q.
REQ-022 Load: q <= load_val when load_val<=MAX, else q <= MAX (clamp); load overrides a simultaneous step.
REQ-023 q never leaves the range 0..MAX after reset or load.
REQ-024 Direction change is legal on any cycle and takes effect on that cycle's step.
REQ-025 Count latency: q reflects a step or load on the rising edge where it is sampled (one-cycle latency).

Reset
REQ-026 On reset=1 at a rising edge: q=0, wrap=0, done=0, prescaler divider=0; reset overrides load and en, and mid-count reset discards all progress.

Configuration
REQ-027 With COUNTER_PRESCALE_EN defined, an internal divider counts en=1 cycles 0..PRESCALE-1.
    - A step occurs only on the en cycle where the divider equals PRESCALE-1; the divider then returns to 0.
    - load and reset clear the divider; en=0 holds the divider.
REQ-028 With COUNTER_PRESCALE_EN undefined: no divider logic, every en=1 cycle is a step, and PRESCALE is ignored.

Verification
REQ-029 Reset held 3 cycles, then en=0 -> q=0, wrap=0, done=0 throughout.
REQ-030 WIDTH=16, MAX=9, up=1, en=1 for 12 cycles from 0 -> q=0,1,...,9,0,1; wrap=1 only in the cycle after q 9->0.
REQ-031 MAX=9, q=0, up=0, en=1 -> q=9, then 8; wrap pulse after 0->9.
REQ-032 load=1, load_val=5, en=1 same cycle -> q=5 next cycle, no step; load_val=20 with MAX=9 -> q=9.
REQ-033 ONESHOT=1, MAX=3, up=1, en=1 -> q=0,1,2,3,3,3; done=1 from the cycle after terminal; a later load of 0 -> done=0, counting resumes.
REQ-034 COUNTER_PRESCALE_EN, PRESCALE=4, en=1 continuous -> q increments every 4th cycle; en low for 2 cycles stretches the interval by 2; reset mid-count -> q=0 and divider=0.
